// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared constants and digit-packing helpers for the timer
//                datapath (BCD counter chain, display decoders, timer FSM).
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Width of one packed BCD digit
  localparam int BCD_W   = 4;
  // Largest legal value of a BCD digit
  localparam int BCD_MAX = 9;
  // Modulus of an ordinary (non-MSD) digit
  localparam int BCD_MOD = BCD_MAX + 1;

  // Bit position of the least-significant bit of digit i in a packed bus
  function automatic int digit_lsb(input int i);
    return i * BCD_W;
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit register with a configurable modulus, up/down
//                stepping, parallel load with clamp to modulus-1, and
//                combinational at_min / at_max boundary flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
  import timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic             step,
  input  logic             up,
  input  logic             ld,
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] q,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] q_q;

  // Next digit value: load (clamped) has priority over a step
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = (din > MAX_V) ? MAX_V : din;
    end else if (step) begin
      if (up) begin
        q_d = (q_q == MAX_V) ? '0 : q_q + BCD_W'(1);
      end else begin
        q_d = (q_q == '0) ? MAX_V : q_q - BCD_W'(1);
      end
    end
  end

  // Digit register, cleared asynchronously
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_min = (q_q == '0);
  assign at_max = (q_q == MAX_V);

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_counter_chain.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_chain
//  Description : DIGITS cascaded BCD digits counting up or down, with a
//                configurable most-significant-digit modulus, saturate/wrap
//                end mode, combinational end/terminal-count flags and a
//                sticky completion flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_chain
  import timer_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int MSD_MOD = 10
) (
  input  logic                      clk,
  input  logic                      clearn,
  input  logic [BCD_W*DIGITS-1:0]   in,
  input  logic                      load,
  input  logic                      en,
  input  logic                      up,
  input  logic                      hold,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      count_end,
  output logic                      tc,
  output logic                      done
);

  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] boundary;
  logic [DIGITS-1:0] step;
  logic              done_d;
  logic              done_q;

  // Per-digit step enables; the carry ripples combinationally through every
  // digit in one cycle. Saturate mode simply suppresses the step at the end.
  always_comb begin
    boundary  = up ? at_max : at_min;
    count_end = &boundary;
    tc        = en & count_end;
    step      = '0;
    step[0]   = en & ~load & ~(hold & count_end);
    for (int i = 1; i < DIGITS; i++) begin
      step[i] = step[i-1] & boundary[i-1];
    end
  end

  // Sticky completion: load clears, reaching the end while enabled sets
  always_comb begin
    done_d = done_q;
    if (load) begin
      done_d = 1'b0;
    end else if (en && count_end) begin
      done_d = 1'b1;
    end
  end

  // Completion flag register
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;

  // Digit array; only the top digit uses the MSD modulus
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int MOD = (i == DIGITS - 1) ? MSD_MOD : BCD_MOD;
    bcd_digit #(
      .MOD (MOD)
    ) u_digit (
      .clk    (clk),
      .clearn (clearn),
      .step   (step[i]),
      .up     (up),
      .ld     (load),
      .din    (in[digit_lsb(i) +: BCD_W]),
      .q      (count[digit_lsb(i) +: BCD_W]),
      .at_min (at_min[i]),
      .at_max (at_max[i])
    );
  end

endmodule : bcd_counter_chain
`default_nettype wire

// File: tb/tb_bcd_counter_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter_chain
//  Description : Directed table-driven bench for bcd_counter_chain with
//                DIGITS=4, MSD_MOD=6, plus hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_chain;

  localparam int DIGITS  = 4;
  localparam int MSD_MOD = 6;
  localparam int W       = 4 * DIGITS;

  logic         clk;
  logic         clearn;
  logic [W-1:0] in;
  logic         load;
  logic         en;
  logic         up;
  logic         hold;
  logic [W-1:0] count;
  logic         count_end;
  logic         tc;
  logic         done;

  int n_checks;
  int n_fail;

  typedef struct {
    logic         ld;
    logic         en;
    logic         up;
    logic         hold;
    logic [W-1:0] din;
    logic [W-1:0] cnt;
    logic         dn;
    logic         ce;
    logic         tc;
  } vec_t;

  vec_t vecs[$];

  bcd_counter_chain #(
    .DIGITS  (DIGITS),
    .MSD_MOD (MSD_MOD)
  ) dut (
    .clk       (clk),
    .clearn    (clearn),
    .in        (in),
    .load      (load),
    .en        (en),
    .up        (up),
    .hold      (hold),
    .count     (count),
    .count_end (count_end),
    .tc        (tc),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld_i, input logic en_i, input logic up_i, input logic hold_i,
                     input logic [W-1:0] din_i, input logic [W-1:0] cnt_i,
                     input logic dn_i, input logic ce_i, input logic tc_i);
    vec_t v;
    v.ld = ld_i; v.en = en_i; v.up = up_i; v.hold = hold_i; v.din = din_i;
    v.cnt = cnt_i; v.dn = dn_i; v.ce = ce_i; v.tc = tc_i;
    vecs.push_back(v);
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rise
  task automatic cycle(input logic ld_i, input logic en_i, input logic up_i,
                       input logic hold_i, input logic [W-1:0] din_i);
    @(negedge clk);
    load = ld_i; en = en_i; up = up_i; hold = hold_i; in = din_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //   ld en up hold  din       count     done end tc
    // down wrap through 0000 to 5999
    add(1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
    add(0, 1, 0, 0, 16'h0000, 16'h5999, 1, 0, 0);
    // down borrows
    add(1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0999, 0, 0, 0);
    add(1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0099, 0, 0, 0);
    // up carry and saturate
    add(1, 0, 1, 1, 16'h5998, 16'h5998, 0, 0, 0);
    add(0, 1, 1, 1, 16'h0000, 16'h5999, 0, 1, 1);
    add(0, 1, 1, 1, 16'h0000, 16'h5999, 1, 1, 1);
    add(0, 1, 1, 1, 16'h0000, 16'h5999, 1, 1, 1);
    // load clamp, load beats enable, load clears done
    add(1, 1, 0, 0, 16'h7CA3, 16'h5993, 0, 0, 0);
    // direction switching
    add(1, 0, 0, 0, 16'h0900, 16'h0900, 0, 0, 0);
    add(0, 1, 1, 0, 16'h0000, 16'h0901, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0900, 0, 0, 0);
    add(0, 1, 1, 0, 16'h0000, 16'h0901, 0, 0, 0);
    // up wrap at the top
    add(1, 0, 1, 0, 16'h5999, 16'h5999, 0, 1, 0);
    add(0, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
    // down saturate at zero
    add(1, 1, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
    add(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 1, 1);
    add(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 1, 1);

    // Reset state
    clearn = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; hold = 1'b0; in = '0;
    #2;
    chk("reset count", 32'(count), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset count_end down", 32'(count_end), 32'h1);
    chk("reset tc", 32'(tc), 32'h0);
    up = 1'b1;
    #1;
    chk("reset count_end up", 32'(count_end), 32'h0);
    up = 1'b0;
    @(negedge clk);
    clearn = 1'b1;

    // Table
    foreach (vecs[i]) begin
      cycle(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].hold, vecs[i].din);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("vec%0d count_end", i), 32'(count_end), 32'(vecs[i].ce));
      chk($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].tc));
    end

    // Async clear mid-count from 0347
    cycle(1, 0, 0, 0, 16'h0347);
    chk("seqA load", 32'(count), 32'h0347);
    cycle(0, 1, 0, 0, 16'h0000);
    chk("seqA step", 32'(count), 32'h0346);
    #2;
    clearn = 1'b0;
    #1;
    chk("seqA async count", 32'(count), 32'h0);
    chk("seqA async done", 32'(done), 32'h0);
    chk("seqA async count_end", 32'(count_end), 32'h1);
    chk("seqA async tc", 32'(tc), 32'h1);
    @(posedge clk);
    #1;
    chk("seqA held in reset", 32'(count), 32'h0);
    @(negedge clk);
    clearn = 1'b1;
    // First edge after release counts (down wrap from 0000)
    @(posedge clk);
    #1;
    chk("seqB first count", 32'(count), 32'h5999);
    chk("seqB done set", 32'(done), 32'h1);
    // Async clear wipes a set done flag without a clock edge
    #2;
    clearn = 1'b0;
    #1;
    chk("seqB async done", 32'(done), 32'h0);
    chk("seqB async count", 32'(count), 32'h0);
    @(negedge clk);
    en = 1'b0;
    clearn = 1'b1;
    @(posedge clk);
    #1;
    chk("seqB idle after release", 32'(count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_counter_chain
`default_nettype wire
